rx_cycle_monitor: RTL and testbench
===================================

// Module: rx_cycle_monitor
// PURPOSE
//   Receive-side partner of the periodic TX cycle generator. Watches the frame-done
//   strobe from the serial receiver and checks that frames arrive at the expected
//   cycle rate (FREQ_OUT_HZ) within a tolerance window. Declares link lock/loss and
//   emits per-frame good/bad strobes for the vector-control loop and the fault logic.
// PARAMETERS
//   FREQ_IN_MHZ  [7:0]  40    system clock frequency, MHz
//   FREQ_OUT_HZ  [15:0] 5000  expected frame rate, Hz
//   TOL_TICKS    [15:0] 400   half-width of the acceptance window, clk ticks
//   LOCK_CNT     [3:0]  4     consecutive good frames needed to lock
//   LOSS_CNT     [3:0]  3     consecutive bad/missed frames needed to drop lock
//   localparam PR = (1000000*FREQ_IN_MHZ)/FREQ_OUT_HZ - 1 (7999 at defaults);
//   window WLO = PR-TOL_TICKS, WHI = PR+TOL_TICKS (7599..8399)
// PORTS
//   clk        in   1   system clock
//   rst        in   1   synchronous reset, active-high
//   rxDone     in   1   one-cycle strobe: receiver finished a frame
//   rxErr      in   1   frame CRC/format error, valid only with rxDone
//   linkOk     out  1   high while in LOCKED
//   frameOk    out  1   one-cycle strobe: good frame accepted while LOCKED
//   frameBad   out  1   one-cycle strobe: bad, early or missed frame while LOCKED
//   linkLost   out  1   one-cycle strobe on LOCKED -> LOST transition
//   period     out  16  last measured good-frame period, clk ticks
//   errTotal   out  16  saturating count of all frameBad events
// BEHAVIOUR
//   Reset: state IDLE, cnt=0, good/miss counters 0, all outputs 0.
//   cnt: 16-bit ticks since last accepted frame; increments every clk outside IDLE.
//   good frame = rxDone & !rxErr & WLO<=cnt<=WHI. First frame in IDLE/LOST is good
//     regardless of cnt.
//   accepted good frame: cnt<=0 next clk; period<=cnt (stats build).
//   early frame (rxDone, cnt<WLO): bad; cnt NOT reset (timing reference kept).
//   rxErr with rxDone in window: bad; cnt<=0 (frame was on time).
//   timeout: cnt==WHI & !rxDone -> miss event; cnt<=TOL_TICKS.
//   rxDone at cnt==WHI has priority over timeout (treated as in-window).
//   States:
//     IDLE   : no timeout. good rxDone -> SYNC, good=1.
//     SYNC   : good -> good+1; good+1==LOCK_CNT -> LOCKED, miss=0.
//              bad -> good=0, stay. timeout -> IDLE.
//     LOCKED : good -> frameOk, miss=0. bad/early/timeout -> frameBad, miss+1;
//              miss+1==LOSS_CNT -> LOST, linkLost.
//     LOST   : no timeout. good rxDone -> SYNC, good=1.
//   All outputs registered: strobes/linkOk change 1 clk after the sampled event.
//   linkOk rises on the clk after the LOCK_CNT-th good rxDone.
//   Only one event per clk; counters never wrap (good/miss stop at thresholds).
// CONFIGURATION
//   RX_CYCLE_STATS_EN defined: period and errTotal implemented (errTotal saturates
//     at 16'hFFFF, cleared only by rst).
//   not defined: period and errTotal tied to 16'h0000; ports remain; state
//     machine unchanged.
// TESTING (defaults, RX_CYCLE_STATS_EN defined)
//   1 rst, rxDone every 8000 clk x4 -> linkOk=1 one clk after 4th; period=7999.
//   2 LOCKED, stop rxDone -> frameBad at cnt=8399, then every 8000 clk;
//     3rd miss -> linkLost pulse, linkOk=0.
//   3 LOCKED, rxDone 7000 clk after last good -> frameBad, errTotal+1;
//     rxDone at 8000 -> frameOk.
//   4 LOCKED, rxDone+rxErr at 8000 -> frameBad, cnt restarts;
//     next clean rxDone 8000 later -> frameOk.
//   5 LOCKED, rxDone at cnt=8399 -> frameOk, no frameBad.
//   6 assert rst mid-LOCKED -> all outputs 0 next clk; 4 good frames needed to relock.

Source files
------------

// File: rtl/rx_cycle_monitor.sv
// Frame-rate lock monitor: checks rxDone spacing against a PR +/- TOL_TICKS window and tracks link lock.
// Build with RX_CYCLE_STATS_EN defined to implement period/errTotal; otherwise they read 0.
module rx_cycle_monitor #(
    parameter logic [7:0]  FREQ_IN_MHZ = 8'd40,
    parameter logic [15:0] FREQ_OUT_HZ = 16'd5000,
    parameter logic [15:0] TOL_TICKS   = 16'd400,
    parameter logic [3:0]  LOCK_CNT    = 4'd4,
    parameter logic [3:0]  LOSS_CNT    = 4'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxDone,
    input  logic        rxErr,
    output logic        linkOk,
    output logic        frameOk,
    output logic        frameBad,
    output logic        linkLost,
    output logic [15:0] period,
    output logic [15:0] errTotal
);
    localparam int          PR_I = (1000000 * int'(FREQ_IN_MHZ)) / int'(FREQ_OUT_HZ) - 1;
    localparam logic [15:0] PR   = 16'(PR_I);
    localparam logic [15:0] WLO  = PR - TOL_TICKS;
    localparam logic [15:0] WHI  = PR + TOL_TICKS;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_LOCKED, S_LOST} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [3:0]  r_good, w_good_nxt;
    logic [3:0]  r_miss, w_miss_nxt;
    logic        r_link_ok, r_frame_ok, r_frame_bad, r_link_lost;
    logic        w_ok_nxt, w_bad_nxt, w_lost_nxt, w_per_upd, w_miss_evt;
    logic        w_in_win, w_good, w_timeout;

    assign w_in_win  = (r_cnt >= WLO) && (r_cnt <= WHI);
    assign w_good    = rxDone && !rxErr && w_in_win;
    assign w_timeout = (r_cnt == WHI) && !rxDone;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_good      <= 4'd0;
            r_miss      <= 4'd0;
            r_link_ok   <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_bad <= 1'b0;
            r_link_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_good      <= w_good_nxt;
            r_miss      <= w_miss_nxt;
            r_link_ok   <= (w_state_nxt == S_LOCKED);
            r_frame_ok  <= w_ok_nxt;
            r_frame_bad <= w_bad_nxt;
            r_link_lost <= w_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_ok_nxt    = 1'b0;
        w_bad_nxt   = 1'b0;
        w_lost_nxt  = 1'b0;
        w_per_upd   = 1'b0;
        w_miss_evt  = 1'b0;
        // IDLE holds the counter; LOST saturates it since no timeout is checked there
        if (r_state == S_IDLE || r_cnt == 16'hFFFF) w_cnt_nxt = r_cnt;
        else                                        w_cnt_nxt = r_cnt + 16'd1;

        case (r_state)
            S_IDLE, S_LOST: begin
                if (rxDone && !rxErr) begin
                    w_cnt_nxt   = 16'd0;
                    w_good_nxt  = 4'd1;
                    w_miss_nxt  = 4'd0;
                    w_state_nxt = (LOCK_CNT <= 4'd1) ? S_LOCKED : S_SYNC;
                end
            end
            S_SYNC: begin
                if (rxDone) begin
                    if (w_good) begin
                        w_cnt_nxt = 16'd0;
                        w_per_upd = 1'b1;
                        if ((r_good + 4'd1) >= LOCK_CNT) begin
                            w_state_nxt = S_LOCKED;
                            w_miss_nxt  = 4'd0;
                        end else begin
                            w_good_nxt = r_good + 4'd1;
                        end
                    end else begin
                        w_good_nxt = 4'd0;
                        if (w_in_win) w_cnt_nxt = 16'd0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 16'd0;
                    w_good_nxt  = 4'd0;
                end
            end
            S_LOCKED: begin
                if (rxDone) begin
                    if (w_good) begin
                        w_cnt_nxt  = 16'd0;
                        w_per_upd  = 1'b1;
                        w_ok_nxt   = 1'b1;
                        w_miss_nxt = 4'd0;
                    end else begin
                        w_miss_evt = 1'b1;
                        // an errored frame that arrived on time still re-anchors the timing
                        if (w_in_win) w_cnt_nxt = 16'd0;
                    end
                end else if (w_timeout) begin
                    w_miss_evt = 1'b1;
                    w_cnt_nxt  = TOL_TICKS;
                end
                if (w_miss_evt) begin
                    w_bad_nxt  = 1'b1;
                    w_miss_nxt = r_miss + 4'd1;
                    if ((r_miss + 4'd1) >= LOSS_CNT) begin
                        w_state_nxt = S_LOST;
                        w_lost_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign linkOk   = r_link_ok;
    assign frameOk  = r_frame_ok;
    assign frameBad = r_frame_bad;
    assign linkLost = r_link_lost;

`ifdef RX_CYCLE_STATS_EN
    logic [15:0] r_period, r_err_total;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period    <= 16'd0;
            r_err_total <= 16'd0;
        end else begin
            if (w_per_upd) r_period <= r_cnt;
            if (w_bad_nxt && r_err_total != 16'hFFFF) r_err_total <= r_err_total + 16'd1;
        end
    end

    assign period   = r_period;
    assign errTotal = r_err_total;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_per_upd;
    assign period   = 16'h0000;
    assign errTotal = 16'h0000;
`endif
endmodule

// File: tb/tb_rx_cycle_monitor.sv
// Random rxDone timing around the acceptance window, checked every cycle against a timestamp-based model.
module tb_rx_cycle_monitor;
    localparam int FIN   = 1;
    localparam int FOUT  = 5000;
    localparam int TOL   = 10;
    localparam int LOCKN = 4;
    localparam int LOSSN = 3;
    localparam int PR    = (1000000 * FIN) / FOUT - 1;
    localparam int WLO   = PR - TOL;
    localparam int WHI   = PR + TOL;
    localparam int NCYC  = 60000;
    localparam int NEVER = 32'h7fffffff;
    localparam int M_IDLE = 0, M_SYNC = 1, M_LOCKED = 2, M_LOST = 3;
`ifdef RX_CYCLE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rxDone, rxErr;
    logic        linkOk, frameOk, frameBad, linkLost;
    logic [15:0] period, errTotal;

    always #5 clk = ~clk;

    rx_cycle_monitor #(
        .FREQ_IN_MHZ(8'(FIN)), .FREQ_OUT_HZ(16'(FOUT)), .TOL_TICKS(16'(TOL)),
        .LOCK_CNT(4'(LOCKN)), .LOSS_CNT(4'(LOSSN))
    ) dut (
        .clk(clk), .rst(rst), .rxDone(rxDone), .rxErr(rxErr),
        .linkOk(linkOk), .frameOk(frameOk), .frameBad(frameBad), .linkLost(linkLost),
        .period(period), .errTotal(errTotal)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: the timing reference is the cycle at which the tick count reads 0
    int m_mode, m_tref, m_good, m_miss, m_cyc, m_period, m_errtot;
    bit e_ok, e_bad, e_lost, e_link;
    int next_pulse, rst_hold, m_lost_n, d_lost_n, m_ok_n, d_ok_n;
    bit mid_lock_rst_done;

    task automatic model_step(input bit r, input bit d, input bit er);
        int e;
        bit inwin, badev;
        e_ok = 0; e_bad = 0; e_lost = 0; badev = 0;
        if (r) begin
            m_mode = M_IDLE; m_tref = 0; m_good = 0; m_miss = 0;
            m_period = 0; m_errtot = 0; e_link = 0;
            return;
        end
        e = m_cyc - m_tref;
        inwin = (e >= WLO) && (e <= WHI);
        case (m_mode)
            M_IDLE, M_LOST: if (d && !er) begin
                m_tref = m_cyc + 1; m_good = 1; m_miss = 0;
                m_mode = (LOCKN <= 1) ? M_LOCKED : M_SYNC;
            end
            M_SYNC: begin
                if (d) begin
                    if (!er && inwin) begin
                        m_period = e; m_tref = m_cyc + 1; m_good++;
                        if (m_good == LOCKN) begin m_mode = M_LOCKED; m_miss = 0; end
                    end else begin
                        m_good = 0;
                        if (inwin) m_tref = m_cyc + 1;
                    end
                end else if (e == WHI) begin
                    m_mode = M_IDLE; m_good = 0;
                end
            end
            default: begin
                if (d) begin
                    if (!er && inwin) begin
                        e_ok = 1; m_period = e; m_tref = m_cyc + 1; m_miss = 0;
                    end else begin
                        badev = 1;
                        if (inwin) m_tref = m_cyc + 1;
                    end
                end else if (e == WHI) begin
                    badev = 1; m_tref = m_cyc + 1 - TOL;
                end
            end
        endcase
        if (badev) begin
            e_bad = 1; m_miss++;
            if (m_errtot < 65535) m_errtot++;
            if (m_miss == LOSSN) begin m_mode = M_LOST; e_lost = 1; end
        end
        e_link = (m_mode == M_LOCKED);
    endtask

    task automatic schedule();
        int base, en, tgt, r;
        base = m_cyc + 1;
        if (m_mode == M_IDLE || m_mode == M_LOST) begin
            next_pulse = base + int'($urandom_range(0, 299));
            return;
        end
        en = base - m_tref;
        r = int'($urandom_range(0, 15));
        if (r <= 8)       tgt = int'($urandom_range(WLO, WHI));
        else if (r == 9)  tgt = WLO;
        else if (r == 10) tgt = WHI;
        else if (r == 11) tgt = WLO - 1;
        else if (r == 12) tgt = int'($urandom_range(1, WLO - 1));
        else              tgt = -1;
        if (tgt < 0) next_pulse = NEVER;
        else begin
            if (tgt < en) tgt = en;
            next_pulse = m_tref + tgt;
        end
    endtask

    initial begin
        int prev_mode, prev_ref;
        rst = 1'b1; rxDone = 1'b0; rxErr = 1'b0;
        m_cyc = 0; next_pulse = NEVER; rst_hold = 2;
        m_lost_n = 0; d_lost_n = 0; m_ok_n = 0; d_ok_n = 0; mid_lock_rst_done = 0;
        model_step(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < NCYC; k++) begin
            check_val("flags", {28'd0, linkOk, frameOk, frameBad, linkLost},
                      {28'd0, e_link, e_ok, e_bad, e_lost});
            check_val("period", {16'd0, period}, STATS ? m_period : 0);
            check_val("errTotal", {16'd0, errTotal}, STATS ? m_errtot : 0);
            if (linkLost) d_lost_n++;
            if (frameOk) d_ok_n++;
            if (e_lost) m_lost_n++;
            if (e_ok) m_ok_n++;
            if ((!mid_lock_rst_done && k >= 20000 && m_mode == M_LOCKED) || k == 45000) begin
                mid_lock_rst_done = 1;
                rst_hold = 3;
            end
            if (rst_hold > 0) begin rst = 1'b1; rst_hold--; end
            else rst = 1'b0;
            rxDone = !rst && (m_cyc == next_pulse);
            rxErr = rxDone ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
            prev_mode = m_mode;
            prev_ref = m_tref;
            model_step(rst, rxDone, rxErr);
            if (rst || rxDone || m_mode != prev_mode || m_tref != prev_ref || next_pulse <= m_cyc)
                schedule();
            m_cyc++;
            @(negedge clk);
        end
        check_val("flags_last", {28'd0, linkOk, frameOk, frameBad, linkLost},
                  {28'd0, e_link, e_ok, e_bad, e_lost});
        check_val("linkLost_count", d_lost_n, m_lost_n);
        check_val("frameOk_count", d_ok_n, m_ok_n);
        check_val("mid_lock_reset_hit", 32'(mid_lock_rst_done), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
